// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin owner of one serial frame transmitter.
// Define TXARB_TIMEOUT_EN for the LAUNCH watchdog (TIMEOUT cycles).
module tx_frame_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*4-1:0]   req_framesize,
  input  logic [NREQ*128-1:0] req_framebits,
  input  logic [7:0]          baud_cfg,
  input  logic                TXI,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic                busy,
  output logic                tf,
  output logic [3:0]          framesize,
  output logic [127:0]        framebits,
  output logic [7:0]          baudrate
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("tx_frame_arbiter: bad NREQ/TIMEOUT");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_BUSY,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   own_q, own_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            tf_q, tf_d;
  logic [3:0]      size_q, size_d;
  logic [127:0]    bits_q, bits_d;
  logic [7:0]      baud_q, baud_d;

`ifdef TXARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  logic            hit;
  logic [IW-1:0]   win;
  logic [IW:0]     cand;

  // First set request at or after ptr, wrapping at NREQ.
  always_comb begin
    hit  = 1'b0;
    win  = ptr_q;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!hit && req[cand[IW-1:0]]) begin
        hit = 1'b1;
        win = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    tf_d    = 1'b0;
    size_d  = size_q;
    bits_d  = bits_q;
    baud_d  = baud_q;
`ifdef TXARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (hit && TXI) begin
          state_d      = S_LOAD;
          own_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          size_d = req_framesize[4*int'(win) +: 4];
          bits_d = req_framebits[128*int'(win) +: 128];
          baud_d = (baud_cfg < 8'd2) ? 8'd2 : baud_cfg;
        end
      end
      S_LOAD: begin
        if (size_q == 4'd0) begin
          state_d = S_DONE;
          done_d  = grant_q;
          err_d   = 1'b1;
        end else begin
          state_d = S_LAUNCH;
          tf_d    = 1'b1;
`ifdef TXARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_LAUNCH: begin
        if (!TXI) begin
          state_d = S_BUSY;
        end else begin
`ifdef TXARB_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT-1)) begin
            state_d = S_DONE;
            done_d  = grant_q;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            tf_d  = 1'b1;
          end
`else
          tf_d = 1'b1;
`endif
        end
      end
      S_BUSY: begin
        if (TXI) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        if (own_q == IW'(NREQ-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = own_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      tf_q    <= 1'b0;
      size_q  <= '0;
      bits_q  <= '0;
      baud_q  <= '0;
`ifdef TXARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      tf_q    <= tf_d;
      size_q  <= size_d;
      bits_q  <= bits_d;
      baud_q  <= baud_d;
`ifdef TXARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign tf        = tf_q;
  assign framesize = size_q;
  assign framebits = bits_q;
  assign baudrate  = baud_q;

  a_grant_1hot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(grant));
  a_done_owner: assert property (
    @(posedge clk) disable iff (!rst_n)
    (done & ~grant) == '0);
  a_tf_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    tf |-> busy);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: randomized bench with a phase-level reference model.
// Define TXARB_TIMEOUT_EN to also exercise the LAUNCH watchdog.
module tb_tx_frame_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 8;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_LAUNCH = 2;
  localparam int P_BUSY   = 3;
  localparam int P_DONE   = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*4-1:0]   req_framesize = '0;
  logic [NREQ*128-1:0] req_framebits = '0;
  logic [7:0]          baud_cfg = '0;
  logic                TXI = 1'b1;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic                err;
  logic                busy;
  logic                tf;
  logic [3:0]          framesize;
  logic [127:0]        framebits;
  logic [7:0]          baudrate;

  always #5 clk = ~clk;

  tx_frame_arbiter #(
    .NREQ(NREQ),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_framesize(req_framesize),
    .req_framebits(req_framebits),
    .baud_cfg(baud_cfg),
    .TXI(TXI),
    .grant(grant),
    .done(done),
    .err(err),
    .busy(busy),
    .tf(tf),
    .framesize(framesize),
    .framebits(framebits),
    .baudrate(baudrate)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, got, exp, $time);
    end
  endtask

  // Reference model: which phase of a frame we are in, who owns it.
  int           m_ph   = P_IDLE;
  int           m_own  = -1;
  int           m_ptr  = 0;
  int           m_cnt  = 0;
  bit           m_err  = 1'b0;
  logic [3:0]   m_size = '0;
  logic [127:0] m_bits = '0;
  logic [7:0]   m_baud = '0;

  function automatic int rr_pick(input logic [NREQ-1:0] r,
                                 input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = P_IDLE; m_own = -1; m_ptr = 0; m_cnt = 0;
      m_err = 1'b0; m_size = '0; m_bits = '0; m_baud = '0;
    end else begin
      case (m_ph)
        P_IDLE: begin
          if (req != '0 && TXI) begin
            m_own  = rr_pick(req, m_ptr);
            m_size = req_framesize[m_own*4 +: 4];
            m_bits = req_framebits[m_own*128 +: 128];
            m_baud = (baud_cfg < 8'd2) ? 8'd2 : baud_cfg;
            m_ph   = P_LOAD;
          end
        end
        P_LOAD: begin
          m_err = (m_size == 4'd0);
          m_ph  = m_err ? P_DONE : P_LAUNCH;
          m_cnt = 0;
        end
        P_LAUNCH: begin
          if (!TXI) m_ph = P_BUSY;
          else begin
            m_cnt++;
`ifdef TXARB_TIMEOUT_EN
            if (m_cnt >= TMO) begin
              m_err = 1'b1;
              m_ph  = P_DONE;
            end
`endif
          end
        end
        P_BUSY: begin
          if (TXI) begin
            m_err = 1'b0;
            m_ph  = P_DONE;
          end
        end
        default: begin
          m_ptr = (m_own + 1) % NREQ;
          m_own = -1;
          m_err = 1'b0;
          m_ph  = P_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_done;
    e_gnt  = '0;
    e_done = '0;
    if (m_own >= 0) e_gnt[m_own] = 1'b1;
    if (m_ph == P_DONE) e_done = e_gnt;
    chk("grant", 128'(grant), 128'(e_gnt));
    chk("done", 128'(done), 128'(e_done));
    chk("err", 128'(err), 128'(m_ph == P_DONE && m_err));
    chk("busy", 128'(busy), 128'(m_ph != P_IDLE));
    chk("tf", 128'(tf), 128'(m_ph == P_LAUNCH));
    chk("framesize", 128'(framesize), 128'(m_size));
    chk("framebits", framebits, m_bits);
    chk("baudrate", 128'(baudrate), 128'(m_baud));
  end

  // Stimulus: transmitter and requester behaviour.
  bit tx_auto = 1'b0;
  bit rq_auto = 1'b0;
  int tx_st   = 0;
  int tx_wait = 0;
  int tx_len  = 0;

  task automatic new_frame(input int i);
    if ($urandom_range(0, 7) == 0) req_framesize[i*4 +: 4] = 4'd0;
    else req_framesize[i*4 +: 4] = 4'($urandom_range(1, 15));
    req_framebits[i*128 +: 128] =
      {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic tx_step();
    case (tx_st)
      0: begin
        if (tf) begin
          if (tx_wait == 0) begin
`ifdef TXARB_TIMEOUT_EN
            if ($urandom_range(0, 5) == 0) tx_st = 2;
            else begin
              TXI = 1'b0; tx_len = $urandom_range(1, 6); tx_st = 1;
            end
`else
            TXI = 1'b0; tx_len = $urandom_range(1, 6); tx_st = 1;
`endif
          end else tx_wait--;
        end else if (!TXI) TXI = 1'b1;
        else if (!busy && $urandom_range(0, 9) == 0) TXI = 1'b0;
      end
      1: begin
        tx_len--;
        if (tx_len <= 0) begin
          TXI = 1'b1; tx_st = 0; tx_wait = $urandom_range(0, 2);
        end
      end
      default: begin
        if (!tf) begin
          tx_st = 0; tx_wait = $urandom_range(0, 2);
        end
      end
    endcase
  endtask

  task automatic rq_step();
    for (int i = 0; i < NREQ; i++) begin
      if (done[i]) begin
        if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        else new_frame(i);
      end else if (grant[i] && $urandom_range(0, 7) == 0) begin
        new_frame(i);
        if ($urandom_range(0, 1) == 0) req[i] = ~req[i];
      end else if (!req[i] && $urandom_range(0, 3) == 0) begin
        new_frame(i);
        req[i] = 1'b1;
      end
    end
    if ($urandom_range(0, 3) == 0) baud_cfg = 8'($urandom_range(0, 1));
    else baud_cfg = 8'($urandom_range(0, 255));
  endtask

  task automatic tick();
    @(negedge clk);
    if (tx_auto) tx_step();
    if (rq_auto) rq_step();
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (busy && c < 300) begin
      tick();
      c++;
    end
    chk(nm, 128'(busy), 128'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int              rr_q[$];
  int              rr_exp[5] = '{0, 1, 2, 3, 0};
  bit              saw_done;
  logic [NREQ-1:0] pg;
  logic [127:0]    b1;
  int              n;

  initial begin : stim
    #1 do_reset();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_baud", 128'(baudrate), 128'(0));

    // Single frame from requester 0.
    req_framesize[3:0]  = 4'd2;
    req_framebits[127:0] = {16'hA55A, 112'h0};
    baud_cfg = 8'd4;
    req[0] = 1'b1;
    tick();
    chk("t1_grant", 128'(grant), 128'(4'b0001));
    chk("t1_tf_early", 128'(tf), 128'(0));
    tick();
    chk("t1_tf", 128'(tf), 128'(1));
    chk("t1_size", 128'(framesize), 128'(2));
    chk("t1_baud", 128'(baudrate), 128'(4));
    chk("t1_bits", 128'(framebits[127:112]), 128'(16'hA55A));
    TXI = 1'b0;
    tick();
    chk("t1_tf_off", 128'(tf), 128'(0));
    tick();
    tick();
    TXI = 1'b1;
    tick();
    chk("t1_done", 128'(done), 128'(4'b0001));
    chk("t1_err", 128'(err), 128'(0));
    req[0] = 1'b0;
    tick();
    chk("t1_idle", 128'(grant), 128'(0));

    // Zero-size frame from requester 2.
    req_framesize[11:8] = 4'd0;
    req[2] = 1'b1;
    tick();
    chk("t3_grant", 128'(grant), 128'(4'b0100));
    tick();
    chk("t3_done", 128'(done), 128'(4'b0100));
    chk("t3_err", 128'(err), 128'(1));
    chk("t3_tf", 128'(tf), 128'(0));
    req[2] = 1'b0;
    tick();

    // Latched frame must survive input churn and req drop.
    b1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_framesize[7:4]    = 4'd5;
    req_framebits[255:128] = b1;
    req[1] = 1'b1;
    tick();
    tick();
    TXI = 1'b0;
    tick();
    req_framebits[255:128] = ~b1;
    req_framesize[7:4] = 4'd9;
    req[1] = 1'b0;
    tick();
    chk("t4_bits", framebits, b1);
    chk("t4_size", 128'(framesize), 128'(5));
    TXI = 1'b1;
    tick();
    chk("t4_done", 128'(done), 128'(4'b0010));
    chk("t4_bits_done", framebits, b1);
    tick();
    chk("t4_bits_idle", framebits, b1);

    // Reset in the middle of a transfer.
    req_framesize[15:12] = 4'd3;
    req[3] = 1'b1;
    tick();
    tick();
    TXI = 1'b0;
    tick();
    chk("t5_busy", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_grant0", 128'(grant), 128'(0));
    chk("t5_busy0", 128'(busy), 128'(0));
    chk("t5_bits0", framebits, 128'(0));
    chk("t5_baud0", 128'(baudrate), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req[3] = 1'b0;
    req_framesize[3:0] = 4'd1;
    req[0] = 1'b1;
    repeat (4) begin
      tick();
      chk("t5_nogrant", 128'(grant), 128'(0));
    end
    TXI = 1'b1;
    tick();
    chk("t5_grant", 128'(grant), 128'(4'b0001));
    tick();
    TXI = 1'b0;
    tick();
    TXI = 1'b1;
    tick();
    chk("t5_done", 128'(done), 128'(4'b0001));
    req[0] = 1'b0;
    tick();

    // Round robin with every requester held.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_framesize[i*4 +: 4] = 4'd3;
      req_framebits[i*128 +: 128] = {4{$urandom()}};
    end
    tx_st = 0; tx_wait = 0; TXI = 1'b1;
    tx_auto = 1'b1;
    req = '1;
    pg = '0;
    saw_done = 1'b1;
    for (int c = 0; c < 600 && rr_q.size() < 5; c++) begin
      tick();
      if (done != '0) saw_done = 1'b1;
      if (pg == '0 && grant != '0) begin
        chk("rr_done_first", 128'(saw_done), 128'(1));
        saw_done = 1'b0;
        for (int i = 0; i < NREQ; i++)
          if (grant[i]) rr_q.push_back(i);
      end
      pg = grant;
    end
    req = '0;
    chk("rr_count", 128'(rr_q.size()), 128'(5));
    for (int i = 0; i < rr_q.size() && i < 5; i++)
      chk("rr_order", 128'(rr_q[i]), 128'(rr_exp[i]));
    wait_idle("rr_idle");

`ifdef TXARB_TIMEOUT_EN
    // Transmitter never leaves idle: watchdog must fire.
    tx_auto = 1'b0;
    TXI = 1'b1;
    req[1] = 1'b1;
    req[2] = 1'b1;
    n = 0;
    while (!tf && n < 10) begin
      tick();
      n++;
    end
    chk("to_tf_seen", 128'(tf), 128'(1));
    n = 0;
    while (tf && n < 50) begin
      n++;
      tick();
    end
    chk("to_tf_cycles", 128'(n), 128'(TMO));
    chk("to_done", 128'(done), 128'(4'b0010));
    chk("to_err", 128'(err), 128'(1));
    req[1] = 1'b0;
    tick();
    tick();
    chk("to_next", 128'(grant), 128'(4'b0100));
    req[2] = 1'b0;
    wait_idle("to_idle");
`endif

    // Randomized traffic against the model.
    tx_st = 0; tx_wait = 0; TXI = 1'b1;
    tx_auto = 1'b1;
    rq_auto = 1'b1;
    repeat (3000) tick();
    rq_auto = 1'b0;
    req = '0;
    wait_idle("rand_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
